// File: rtl/ram_port_arbiter_if.sv
// Bus-master port of the RAM arbiter: FemtoRV32-style one-cycle strobes
// with registered read data and per-direction busy flags.
interface ram_port_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wmask;
  logic            rstrb;
  logic [DW-1:0]   rdata;
  logic            rbusy;
  logic            wbusy;

  modport master (output addr, wdata, wmask, rstrb, input rdata, rbusy, wbusy);
  modport slave  (input addr, wdata, wmask, rstrb, output rdata, rbusy, wbusy);
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two bus masters
// (M0 = CPU, M1 = DMA); per-master request capture plus a 3-state sequencer.
module ram_port_capture #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wmask,
  input  logic            rstrb,
  input  logic            done,
  input  logic            rd_load,
  input  logic [DW-1:0]   ram_rdata,
  output logic            pend,
  output logic            is_read,
  output logic [AW-1:0]   cap_addr,
  output logic [DW-1:0]   cap_wdata,
  output logic [DW/8-1:0] cap_wmask,
  output logic [DW-1:0]   rdata,
  output logic            rbusy,
  output logic            wbusy,
  output logic            err
);
  logic strobe, accept;

  assign strobe = rstrb | (|wmask);
  // A strobe landing on the edge that retires the current request is a legal re-issue
  assign accept = strobe & (~pend | done);
  assign err    = (strobe & pend & ~done) | (rstrb & (|wmask));
  assign rbusy  = pend & is_read;
  assign wbusy  = pend & ~is_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      is_read   <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wmask <= '0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        pend      <= 1'b1;
        is_read   <= ~(|wmask);
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cap_wmask <= wmask;
      end else if (done) begin
        pend <= 1'b0;
      end
      if (rd_load) rdata <= ram_rdata;
    end
  end
endmodule

module ram_port_arbiter #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   m0,
  ram_port_arbiter_if.slave   m1,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  output logic [DW/8-1:0]     ram_wmask,
  output logic                ram_en,
  input  logic [DW-1:0]       ram_rdata,
  output logic                owner,
  output logic                proto_err
);
  localparam int NM = 2;
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  logic [NM-1:0][AW-1:0] req_addr, cap_addr;
  logic [NM-1:0][DW-1:0] req_wdata, cap_wdata, rdata_v;
  logic [NM-1:0][MW-1:0] req_wmask, cap_wmask;
  logic [NM-1:0]         req_rstrb, pend_v, is_read_v, rbusy_v, wbusy_v, err_v;
  logic [NM-1:0]         done, rd_load;

  state_t state, state_nxt;
  logic   grant, grant_nxt, last_grant, last_nxt, owner_q, owner_nxt, proto_q, win;

  assign req_addr  = {m1.addr,  m0.addr};
  assign req_wdata = {m1.wdata, m0.wdata};
  assign req_wmask = {m1.wmask, m0.wmask};
  assign req_rstrb = {m1.rstrb, m0.rstrb};

  assign m0.rdata = rdata_v[0];
  assign m0.rbusy = rbusy_v[0];
  assign m0.wbusy = wbusy_v[0];
  assign m1.rdata = rdata_v[1];
  assign m1.rbusy = rbusy_v[1];
  assign m1.wbusy = wbusy_v[1];

  assign owner     = owner_q;
  assign proto_err = proto_q;

  generate
    for (genvar i = 0; i < NM; i++) begin : g_cap
      ram_port_capture #(.AW(AW), .DW(DW)) u_cap (
        .clk       (clk),
        .reset     (reset),
        .addr      (req_addr[i]),
        .wdata     (req_wdata[i]),
        .wmask     (req_wmask[i]),
        .rstrb     (req_rstrb[i]),
        .done      (done[i]),
        .rd_load   (rd_load[i]),
        .ram_rdata (ram_rdata),
        .pend      (pend_v[i]),
        .is_read   (is_read_v[i]),
        .cap_addr  (cap_addr[i]),
        .cap_wdata (cap_wdata[i]),
        .cap_wmask (cap_wmask[i]),
        .rdata     (rdata_v[i]),
        .rbusy     (rbusy_v[i]),
        .wbusy     (wbusy_v[i]),
        .err       (err_v[i])
      );
    end
  endgenerate

  // Both pending: the master not granted last time wins
  assign win = (pend_v == 2'b11) ? ~last_grant : pend_v[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
      owner_q    <= owner_nxt;
      proto_q    <= proto_q | (|err_v);
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    owner_nxt = owner_q;
    done      = '0;
    rd_load   = '0;
    ram_en    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wmask = '0;
    case (state)
      IDLE: begin
        if (|pend_v) begin
          grant_nxt = win;
          last_nxt  = win;
          owner_nxt = win;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // Gated by reset so an abandoned write never lands on the reset edge
        if (!reset) begin
          ram_en   = 1'b1;
          ram_addr = cap_addr[grant];
          if (!is_read_v[grant]) begin
            ram_wdata = cap_wdata[grant];
            ram_wmask = cap_wmask[grant];
          end
        end
        if (is_read_v[grant]) begin
          state_nxt = RDATA;
        end else begin
          done[grant] = 1'b1;
          state_nxt   = IDLE;
        end
      end
      RDATA: begin
        done[grant]    = 1'b1;
        rd_load[grant] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: drivers push expected RAM accesses,
// grant order and read data; a negedge monitor pops and compares.
module tb_ram_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wmask;
  } acc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [3:0]    ram_wmask;
  logic          ram_en, owner, proto_err;

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_en    (ram_en),
    .ram_rdata (ram_rdata),
    .owner     (owner),
    .proto_err (proto_err)
  );

  logic [31:0] mem [0:16383];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wmask[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  int checks = 0;
  int failures = 0;
  acc_t        acc_q0[$], acc_q1[$];
  logic [31:0] rd_q0[$], rd_q1[$];
  logic        grant_q[$];
  int          gcnt[2];
  int          en_cyc[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: every RAM access and every completed read is popped against the scoreboard
  initial begin
    logic prb0, prb1, prst;
    acc_t a;
    prb0 = 0; prb1 = 0; prst = 1;
    forever begin
      @(negedge clk);
      if (ram_en) begin
        if (grant_q.size() == 0) fail("grant_unexpected");
        else check("grant_order", 64'(owner), 64'(grant_q.pop_front()));
        gcnt[owner]++;
        en_cyc[owner] = cyc;
        if (owner == 1'b0) begin
          if (acc_q0.size() == 0) fail("m0_access_unexpected");
          else begin a = acc_q0.pop_front(); check("m0_access", 64'({ram_addr, ram_wdata, ram_wmask}), 64'(a)); end
        end else begin
          if (acc_q1.size() == 0) fail("m1_access_unexpected");
          else begin a = acc_q1.pop_front(); check("m1_access", 64'({ram_addr, ram_wdata, ram_wmask}), 64'(a)); end
        end
      end
      if (prb0 && !m0_if.rbusy && !prst) begin
        if (rd_q0.size() == 0) fail("m0_rdata_unexpected");
        else check("m0_rdata", 64'(m0_if.rdata), 64'(rd_q0.pop_front()));
      end
      if (prb1 && !m1_if.rbusy && !prst) begin
        if (rd_q1.size() == 0) fail("m1_rdata_unexpected");
        else check("m1_rdata", 64'(m1_if.rdata), 64'(rd_q1.pop_front()));
      end
      prb0 = m0_if.rbusy;
      prb1 = m1_if.rbusy;
      prst = reset;
    end
  end

  task automatic set_m(input int idx, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic r);
    if (idx == 0) begin
      m0_if.addr = a; m0_if.wdata = d; m0_if.wmask = m; m0_if.rstrb = r;
    end else begin
      m1_if.addr = a; m1_if.wdata = d; m1_if.wmask = m; m1_if.rstrb = r;
    end
  endtask

  task automatic expect_acc(input int idx, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    acc_t e;
    e.addr = a; e.wdata = (m != 0) ? d : 32'h0; e.wmask = m;
    if (idx == 0) acc_q0.push_back(e); else acc_q1.push_back(e);
  endtask

  task automatic pulse(input int idx, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic r);
    @(posedge clk); #1;
    set_m(idx, a, d, m, r);
    @(posedge clk); #1;
    set_m(idx, '0, '0, '0, 1'b0);
  endtask

  task automatic busy_len(input int idx, input bit rd, output int n);
    logic b;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      b = (idx == 0) ? (rd ? m0_if.rbusy : m0_if.wbusy) : (rd ? m1_if.rbusy : m1_if.wbusy);
      if (b) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (!m0_if.rbusy && !m0_if.wbusy && !m1_if.rbusy && !m1_if.wbusy) begin ok = 1; break; end
    end
    if (!ok) fail("wait_idle_timeout");
  endtask

  task automatic wait_access(input int idx);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ram_en && owner == idx[0]) begin ok = 1; break; end
    end
    if (!ok) fail("wait_access_timeout");
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    set_m(0, '0, '0, '0, 1'b0);
    set_m(1, '0, '0, '0, 1'b0);
    mem[14'h010] <= 32'hDEADBEEF;
    mem[14'h020] <= 32'hAABBCCDD;
    mem[14'h030] <= 32'hCAFEF00D;
    mem[14'h040] <= 32'h11223344;
    mem[14'h050] <= 32'h55667788;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en", 64'(ram_en), 64'h0);
    check("rst_owner_proto", 64'({owner, proto_err}), 64'h0);
    check("rst_busy", 64'({m0_if.rbusy, m0_if.wbusy, m1_if.rbusy, m1_if.wbusy}), 64'h0);
    check("rst_rdata", 64'({m0_if.rdata, m1_if.rdata}), 64'h0);
    @(posedge clk); #1 reset = 1'b0;

    // uncontended read
    grant_q.push_back(1'b0); expect_acc(0, 14'h010, 0, 4'h0); rd_q0.push_back(32'hDEADBEEF);
    pulse(0, 14'h010, 32'h0, 4'h0, 1'b1);
    busy_len(0, 1, n);
    check("t1_rbusy_cycles", 64'(n), 64'd3);
    check("t1_rdata_held", 64'(m0_if.rdata), 64'hDEADBEEF);

    // uncontended byte-lane write
    grant_q.push_back(1'b1); expect_acc(1, 14'h020, 32'h12345678, 4'b0100);
    pulse(1, 14'h020, 32'h12345678, 4'b0100, 1'b0);
    busy_len(1, 0, n);
    check("t2_wbusy_cycles", 64'(n), 64'd2);
    check("t2_ram_byte2", 64'(mem[14'h020]), 64'hAA34CCDD);

    // simultaneous M0 read / M1 write straight after reset
    apply_reset();
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    expect_acc(0, 14'h010, 0, 4'h0); rd_q0.push_back(32'hDEADBEEF);
    expect_acc(1, 14'h050, 32'hA5A5A5A5, 4'hF);
    @(posedge clk); #1;
    set_m(0, 14'h010, 32'h0, 4'h0, 1'b1);
    set_m(1, 14'h050, 32'hA5A5A5A5, 4'hF, 1'b0);
    @(posedge clk); #1;
    set_m(0, '0, '0, '0, 1'b0); set_m(1, '0, '0, '0, 1'b0);
    wait_idle(40);
    check("t3_owner", 64'(owner), 64'h1);
    check("t3_m1_delay", 64'(en_cyc[1] - en_cyc[0]), 64'd3);
    check("t3_ram_write", 64'(mem[14'h050]), 64'hA5A5A5A5);

    // continuous contention, re-strobing in the cycle each access retires
    apply_reset();
    gcnt[0] = 0; gcnt[1] = 0;
    for (int k = 0; k < 8; k++) grant_q.push_back(k[0]);
    for (int k = 0; k < 4; k++) begin
      expect_acc(0, AW'(14'h100 + k), 32'h0A000000 + k, 4'hF);
      expect_acc(1, AW'(14'h200 + k), 32'h0B000000 + k, 4'hF);
    end
    @(posedge clk); #1;
    set_m(0, 14'h100, 32'h0A000000, 4'hF, 1'b0);
    set_m(1, 14'h200, 32'h0B000000, 4'hF, 1'b0);
    @(posedge clk); #1;
    set_m(0, '0, '0, '0, 1'b0); set_m(1, '0, '0, '0, 1'b0);
    fork
      for (int k = 1; k < 4; k++) begin
        wait_access(0);
        set_m(0, AW'(14'h100 + k), 32'h0A000000 + k, 4'hF, 1'b0);
        @(posedge clk); #1 set_m(0, '0, '0, '0, 1'b0);
      end
      for (int j = 1; j < 4; j++) begin
        wait_access(1);
        set_m(1, AW'(14'h200 + j), 32'h0B000000 + j, 4'hF, 1'b0);
        @(posedge clk); #1 set_m(1, '0, '0, '0, 1'b0);
      end
    join
    wait_idle(40);
    check("t4_grants_m0", 64'(gcnt[0]), 64'd4);
    check("t4_grants_m1", 64'(gcnt[1]), 64'd4);
    check("t4_no_proto_err", 64'(proto_err), 64'h0);
    check("t4_ram_last", 64'({mem[14'h103], mem[14'h203]}), {32'h0A000003, 32'h0B000003});

    // strobe while pending: flagged, original read unaffected
    apply_reset();
    grant_q.push_back(1'b1); expect_acc(1, 14'h030, 0, 4'h0); rd_q1.push_back(32'hCAFEF00D);
    pulse(1, 14'h030, 32'h0, 4'h0, 1'b1);
    set_m(1, 14'h040, 32'h0, 4'h0, 1'b1);
    @(posedge clk); #1 set_m(1, '0, '0, '0, 1'b0);
    @(negedge clk);
    check("t5_proto_set", 64'(proto_err), 64'h1);
    wait_idle(40);
    repeat (3) @(negedge clk);
    check("t5_proto_sticky", 64'(proto_err), 64'h1);

    // rstrb with wmask: treated as a write and flagged
    apply_reset();
    @(negedge clk);
    check("t5b_proto_clear", 64'(proto_err), 64'h0);
    grant_q.push_back(1'b0); expect_acc(0, 14'h040, 32'h000000EE, 4'b0001);
    pulse(0, 14'h040, 32'h000000EE, 4'b0001, 1'b1);
    busy_len(0, 0, n);
    check("t5b_wbusy_cycles", 64'(n), 64'd2);
    check("t5b_ram", 64'(mem[14'h040]), 64'h112233EE);
    check("t5b_proto_set", 64'(proto_err), 64'h1);

    // reset during RDATA of an M0 read
    apply_reset();
    grant_q.push_back(1'b0); expect_acc(0, 14'h010, 0, 4'h0); rd_q0.push_back(32'hDEADBEEF);
    pulse(0, 14'h010, 32'h0, 4'h0, 1'b1);
    wait_idle(40);
    grant_q.push_back(1'b0); expect_acc(0, 14'h030, 0, 4'h0);
    pulse(0, 14'h030, 32'h0, 4'h0, 1'b1);
    wait_access(0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_rbusy", 64'(m0_if.rbusy), 64'h0);
    check("t6_ram_en", 64'(ram_en), 64'h0);
    check("t6_rdata", 64'(m0_if.rdata), 64'h0);

    // reset on the edge that would commit a write
    grant_q.push_back(1'b1); expect_acc(1, 14'h040, 32'hFFFFFFFF, 4'hF);
    pulse(1, 14'h040, 32'hFFFFFFFF, 4'hF, 1'b0);
    wait_access(1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_write_abandoned", 64'(mem[14'h040]), 64'h112233EE);
    check("t6_wbusy", 64'(m1_if.wbusy), 64'h0);

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(acc_q0.size() + acc_q1.size() + rd_q0.size() + rd_q1.size() + grant_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
